// File: rtl/abs_arb_pkg.sv
// Shared types and helpers for the round-robin absolute-value arbiter.
package abs_arb_pkg;

    localparam int ABS_OPND_W   = 9;
    localparam int ABS_MAG_W    = 8;
    localparam int ABS_ID_MAX_W = 3;
    localparam logic [ABS_MAG_W-1:0] ABS_SAT_VAL = 8'hFF;

    // Result stage contents; id is sized for the largest supported requester count.
    typedef struct packed {
        logic [ABS_ID_MAX_W-1:0] id;
        logic [ABS_MAG_W-1:0]    absv;
        logic                    neg;
        logic                    sat;
    } abs_res_t;

    function automatic logic [ABS_ID_MAX_W-1:0] rr_next_ptr(
        input logic [ABS_ID_MAX_W-1:0] winner,
        input int                      n_req
    );
        if (int'(winner) >= n_req - 1) begin
            return '0;
        end
        return winner + ABS_ID_MAX_W'(1);
    endfunction

endpackage

// File: rtl/abs_val_sat.sv
// Combinational 9-bit signed to 8-bit magnitude, with sign and clamp flags.
module abs_val_sat
    import abs_arb_pkg::*;
(
    input  logic [ABS_OPND_W-1:0] opnd,
    output logic [ABS_MAG_W-1:0]  absv,
    output logic                  neg,
    output logic                  sat
);

    always_comb begin
        neg = opnd[ABS_OPND_W-1];
        sat = (opnd == {1'b1, {ABS_MAG_W{1'b0}}});
        if (sat) begin
            absv = ABS_SAT_VAL;
        end else if (neg) begin
            absv = ~opnd[ABS_MAG_W-1:0] + ABS_MAG_W'(1);
        end else begin
            absv = opnd[ABS_MAG_W-1:0];
        end
    end

endmodule

// File: rtl/abs_val_arbiter.sv
// Round-robin arbiter sharing one abs-value unit; two-stage grant/result pipe.
// Define ABS_VAL_ARB_STATS_EN to add per-requester saturating grant counters.
module abs_val_arbiter
    import abs_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
)
(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ABS_OPND_W-1:0] operand,
    output logic [N_REQ-1:0]            ack,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ID_W-1:0]             res_id,
    output logic [ABS_MAG_W-1:0]        res_absv,
    output logic                        res_neg,
    output logic                        res_sat,
    output logic                        busy
`ifdef ABS_VAL_ARB_STATS_EN
    ,
    input  logic                        stats_clear,
    output logic [N_REQ*16-1:0]         grant_count
`endif
);

    logic [ID_W-1:0]       ptr;
    logic                  s1_valid;
    logic [ABS_OPND_W-1:0] s1_opnd;
    logic [ID_W-1:0]       s1_id;
    logic                  s2_valid;
    abs_res_t              s2;

    logic                  s2_free;
    logic                  grant_ok;
    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       cand;
    logic [ABS_OPND_W-1:0] win_opnd;
    logic [ABS_MAG_W-1:0]  mag;
    logic                  mag_neg;
    logic                  mag_sat;
    logic                  unused_id_hi;

    assign s2_free  = !s2_valid || res_ready;
    assign grant_ok = !s1_valid || s2_free;

    // First requester at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_opnd = operand[i*ABS_OPND_W +: ABS_OPND_W];
            end
        end
    end

    abs_val_sat u_abs (
        .opnd (s1_opnd),
        .absv (mag),
        .neg  (mag_neg),
        .sat  (mag_sat)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_opnd  <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2       <= '0;
            ack      <= '0;
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2 <= '{id: ABS_ID_MAX_W'(s1_id), absv: mag, neg: mag_neg, sat: mag_sat};
                end
            end
            ack <= '0;
            if (grant_ok) begin
                s1_valid <= win_found;
                if (win_found) begin
                    s1_opnd <= win_opnd;
                    s1_id   <= win_idx;
                    ptr     <= ID_W'(rr_next_ptr(ABS_ID_MAX_W'(win_idx), N_REQ));
                    ack     <= N_REQ'(1) << win_idx;
                end
            end
        end
    end

    assign res_valid    = s2_valid;
    assign res_id       = s2.id[ID_W-1:0];
    assign res_absv     = s2.absv;
    assign res_neg      = s2.neg;
    assign res_sat      = s2.sat;
    assign busy         = s1_valid;
    assign unused_id_hi = ^s2.id;

`ifdef ABS_VAL_ARB_STATS_EN
    logic [15:0] cnt [N_REQ];

    // Counts at the edge that raises ack; clear wins over a coincident grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stats_clear) begin
                    cnt[i] <= '0;
                end else if (grant_ok && win_found && win_idx == ID_W'(i) && cnt[i] != 16'hFFFF) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_count[i*16 +: 16] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_abs_val_arbiter.sv
// Randomized and directed bench for abs_val_arbiter against a cycle-level reference model.
module tb_abs_val_arbiter;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N*9-1:0] operand;
    logic [N-1:0]  ack;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_id;
    logic [7:0]    res_absv;
    logic          res_neg;
    logic          res_sat;
    logic          busy;
    logic          stats_clear;
`ifdef ABS_VAL_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    abs_val_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .operand   (operand),
        .ack       (ack),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_absv  (res_absv),
        .res_neg   (res_neg),
        .res_sat   (res_sat),
        .busy      (busy)
`ifdef ABS_VAL_ARB_STATS_EN
        ,
        .stats_clear (stats_clear),
        .grant_count (grant_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int op_val [N];
    bit auto_drop = 1'b1;

    // Reference model: occupancy of the grant and result stages plus arbitration pointer.
    int m_ptr;
    bit m_s1, m_s2;
    int m_s1_id, m_s1_op, m_s2_id, m_s2_op;
    int m_ack;
    int m_cnt [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_abs(input int v);
        if (v < 0) return (-v > 255) ? 255 : -v;
        return v;
    endfunction

    task automatic drive_operands();
        logic [8:0] t;
        for (int i = 0; i < N; i++) begin
            t = 9'(op_val[i]);
            operand[i*9 +: 9] = t;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_ack = -1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit s2_free, can;
        int w;
        s2_free = !m_s2 || res_ready;
        can     = !m_s1 || s2_free;
        if (s2_free) begin
            if (m_s1) begin
                m_s2_id = m_s1_id;
                m_s2_op = m_s1_op;
            end
            m_s2 = m_s1;
        end
        w = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            m_s1 = (w >= 0);
            if (w >= 0) begin
                m_s1_id = w;
                m_s1_op = op_val[w];
                m_ptr   = (w + 1) % N;
            end
        end
        m_ack = w;
        if (stats_clear) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (w >= 0 && m_cnt[w] < 65535) begin
            m_cnt[w]++;
        end
    endtask

    task automatic check_outputs();
        chk("ack", ack, (m_ack < 0) ? 0 : (1 << m_ack));
        chk("busy", busy, m_s1);
        chk("res_valid", res_valid, m_s2);
        if (m_s2) begin
            chk("res_id", res_id, m_s2_id);
            chk("res_absv", res_absv, ref_abs(m_s2_op));
            chk("res_neg", res_neg, m_s2_op < 0);
            chk("res_sat", res_sat, m_s2_op == -256);
        end
`ifdef ABS_VAL_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_count", grant_count[i*16 +: 16], m_cnt[i]);
`endif
    endtask

    task automatic tick();
        drive_operands();
        model_step();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        if (auto_drop) begin
            for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_id"}, res_id, 0);
        chk({tag, "_absv"}, res_absv, 0);
        chk({tag, "_neg"}, res_neg, 0);
        chk({tag, "_sat"}, res_sat, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int exp_mag   [5] = '{0, 1, 1, 0, 127};

        reset_n     = 1'b0;
        req         = '0;
        res_ready   = 1'b1;
        stats_clear = 1'b0;
        for (int i = 0; i < N; i++) op_val[i] = 0;
        drive_operands();
        model_reset();
        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // All requesting: grant order wraps 0,1,2,3,0
        auto_drop = 1'b0;
        op_val = '{1, -1, 0, 127};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_order", ack, 1 << exp_order[k]);
            if (k > 0) chk("rr_absv", res_absv, exp_mag[k]);
        end

        // Reset while both stages hold data; pointer must restart at 0
        pulse_reset();
        tick();
        chk("ptr_after_reset", ack, 4'b0001);
        req = '0;
        auto_drop = 1'b1;
        repeat (3) tick();

        // Single request
        op_val[0] = -11;
        req = 4'b0001;
        tick();
        chk("single_ack", ack, 4'b0001);
        tick();
        chk("single_valid", res_valid, 1);
        chk("single_id", res_id, 0);
        chk("single_absv", res_absv, 11);
        chk("single_neg", res_neg, 1);
        repeat (2) tick();

        // Saturation boundary
        op_val[2] = -256;
        req = 4'b0100;
        repeat (2) tick();
        chk("sat_absv", res_absv, 255);
        chk("sat_flag", res_sat, 1);
        op_val[3] = -255;
        req = 4'b1000;
        repeat (2) tick();
        chk("m255_absv", res_absv, 255);
        chk("m255_sat", res_sat, 0);
        repeat (2) tick();

        // Backpressure with two requests pending behind full stages
        res_ready = 1'b0;
        op_val[0] = 5;
        op_val[1] = -7;
        req = 4'b0011;
        repeat (2) tick();
        op_val[2] = 9;
        op_val[3] = -3;
        req = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_no_ack", ack, 0);
            chk("bp_busy", busy, 1);
            chk("bp_hold", res_absv, 5);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_drain1", res_absv, 7);
        tick();
        chk("bp_drain2", res_absv, 9);
        tick();
        chk("bp_drain3", res_absv, 3);
        repeat (2) tick();

`ifdef ABS_VAL_ARB_STATS_EN
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            op_val[2] = k;
            req = 4'b0100;
            repeat (2) tick();
        end
        chk("stats_five", grant_count[2*16 +: 16], 5);
        req = 4'b0100;
        stats_clear = 1'b1;
        tick();
        chk("stats_clear", grant_count[2*16 +: 16], 0);
        stats_clear = 1'b0;
        repeat (2) tick();
`endif

        // Randomized traffic with backpressure and withdrawn requests
        for (int c = 0; c < 3000; c++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        op_val[i] = ($urandom_range(0, 7) == 0) ? -256 : int'($urandom_range(0, 511)) - 256;
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
